// File: rtl/io_bus_pkg.sv
// io_bus_pkg: owner ids and load/store size encodings shared by core, arbiter and datapath
package io_bus_pkg;
  localparam int MEM_CTRL_W = 2;
  typedef enum logic {OWNER_CORE = 1'b0, OWNER_M1 = 1'b1} owner_e;
  typedef enum logic [MEM_CTRL_W-1:0] {MEM_BYTE = 2'd0, MEM_HALF = 2'd1, MEM_WORD = 2'd2} mem_ctrl_e;
endpackage

// File: rtl/io_bus_arbiter_if.sv
// io_bus_arbiter_if: both master ports plus the shared datapath port of the I/O bus
interface io_bus_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  import io_bus_pkg::*;
  logic                  m0_req, m0_we, m0_gnt, m0_stall;
  logic [MEM_CTRL_W-1:0] m0_mem_ctrl;
  logic [ADDR_W-1:0]     m0_addr;
  logic [DATA_W-1:0]     m0_wdata, m0_rdata;
  logic                  m1_req, m1_we, m1_lock, m1_gnt;
  logic [MEM_CTRL_W-1:0] m1_mem_ctrl;
  logic [ADDR_W-1:0]     m1_addr;
  logic [DATA_W-1:0]     m1_wdata, m1_rdata;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata, bus_rdata;
  logic                  bus_we;
  logic [MEM_CTRL_W-1:0] bus_mem_ctrl;
  logic                  owner;
  modport slave (
    input  m0_req, m0_we, m0_mem_ctrl, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_mem_ctrl, m1_addr, m1_wdata, m1_lock,
    input  bus_rdata,
    output m0_gnt, m0_stall, m0_rdata, m1_gnt, m1_rdata,
    output bus_addr, bus_wdata, bus_we, bus_mem_ctrl, owner
  );
  modport master (
    output m0_req, m0_we, m0_mem_ctrl, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_mem_ctrl, m1_addr, m1_wdata, m1_lock,
    output bus_rdata,
    input  m0_gnt, m0_stall, m0_rdata, m1_gnt, m1_rdata,
    input  bus_addr, bus_wdata, bus_we, bus_mem_ctrl, owner
  );
endinterface

// File: rtl/io_bus_mux.sv
// io_bus_mux: combinational owner select of address, write data, size and write enable
module io_bus_mux
  import io_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  owner_e                owner_i,
  input  logic                  en_i,
  input  logic                  m0_we_i,
  input  logic                  m0_gnt_i,
  input  logic [MEM_CTRL_W-1:0] m0_mem_ctrl_i,
  input  logic [ADDR_W-1:0]     m0_addr_i,
  input  logic [DATA_W-1:0]     m0_wdata_i,
  input  logic                  m1_we_i,
  input  logic                  m1_gnt_i,
  input  logic [MEM_CTRL_W-1:0] m1_mem_ctrl_i,
  input  logic [ADDR_W-1:0]     m1_addr_i,
  input  logic [DATA_W-1:0]     m1_wdata_i,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [DATA_W-1:0]     bus_wdata_o,
  output logic [MEM_CTRL_W-1:0] bus_mem_ctrl_o,
  output logic                  bus_we_o
);
  logic sel;
  assign sel            = owner_i == OWNER_M1;
  assign bus_addr_o     = sel ? m1_addr_i : m0_addr_i;
  assign bus_wdata_o    = sel ? m1_wdata_i : m0_wdata_i;
  assign bus_mem_ctrl_o = sel ? m1_mem_ctrl_i : m0_mem_ctrl_i;
  // en_i kills any write while reset is held, even an in-flight beat
  assign bus_we_o       = en_i & (sel ? (m1_we_i & m1_gnt_i) : (m0_we_i & m0_gnt_i));
endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: core-parked two-master arbiter with burst lock and starvation guard
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 16,
  parameter int STARVE_LIM = 8
) (
  input logic             clk,
  input logic             reset,
  io_bus_arbiter_if.slave bus
);
  localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  localparam int SW = $clog2(STARVE_LIM + 1);
  owner_e        owner_q, owner_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          own_m1, m0_gnt, m1_gnt, beat_max, starved, take, yield;
  assign own_m1   = owner_q == OWNER_M1;
  assign m0_gnt   = bus.m0_req & ~own_m1;
  assign m1_gnt   = bus.m1_req & own_m1 & reset;
  assign beat_max = beat_q == BW'(MAX_BURST - 1);
  assign starved  = starve_q == SW'(STARVE_LIM);
  // core keeps the bus on a tie until master 1 has lost STARVE_LIM times
  assign take     = bus.m1_req & (~bus.m0_req | starved);
  assign yield    = ~bus.m1_req | (bus.m0_req & (~bus.m1_lock | (beat_max & m1_gnt)));
  always_comb begin
    owner_d  = own_m1 ? (yield ? OWNER_CORE : OWNER_M1) : (take ? OWNER_M1 : OWNER_CORE);
    beat_d   = (own_m1 & yield) ? '0 : (m1_gnt & ~beat_max) ? beat_q + 1'b1 : beat_q;
    starve_d = (~own_m1 & take) ? '0
             : (~own_m1 & bus.m0_req & bus.m1_req & ~starved) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner_q  <= OWNER_CORE;
      beat_q   <= '0;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
    end
  assign bus.m0_gnt   = m0_gnt;
  assign bus.m1_gnt   = m1_gnt;
  assign bus.m0_stall = bus.m0_req & ~m0_gnt;
  assign bus.m0_rdata = bus.bus_rdata;
  assign bus.m1_rdata = bus.bus_rdata;
  assign bus.owner    = own_m1;
  io_bus_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .owner_i        (owner_q),
    .en_i           (reset),
    .m0_we_i        (bus.m0_we),
    .m0_gnt_i       (m0_gnt),
    .m0_mem_ctrl_i  (bus.m0_mem_ctrl),
    .m0_addr_i      (bus.m0_addr),
    .m0_wdata_i     (bus.m0_wdata),
    .m1_we_i        (bus.m1_we),
    .m1_gnt_i       (m1_gnt),
    .m1_mem_ctrl_i  (bus.m1_mem_ctrl),
    .m1_addr_i      (bus.m1_addr),
    .m1_wdata_i     (bus.m1_wdata),
    .bus_addr_o     (bus.bus_addr),
    .bus_wdata_o    (bus.bus_wdata),
    .bus_mem_ctrl_o (bus.bus_mem_ctrl),
    .bus_we_o       (bus.bus_we)
  );
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: vector table, corner sequences and random traffic against a reference model
module tb_io_bus_arbiter;
  import io_bus_pkg::*;
  localparam int MAXB = 16;
  localparam int STL  = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic m_owner = 1'b0;
  int   m_beats = 0;
  int   m_wins = 0;
  always #5 clk = ~clk;
  io_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  io_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB), .STARVE_LIM(STL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  typedef struct packed {
    logic m0r, m0w, m1r, m1w, lk;
    logic eo, eg0, eg1, ewe;
  } vec_t;
  vec_t tv [9];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask
  function automatic logic pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction
  task automatic model_reset();
    m_owner = 1'b0;
    m_beats = 0;
    m_wins  = 0;
  endtask
  // Model: master 1 enters when the core is idle or after STL lost ties, and
  // leaves when it stops asking, or the waiting core is owed the bus.
  task automatic model_edge();
    int nb;
    if (!m_owner) begin
      if (bus.m1_req && (!bus.m0_req || m_wins >= STL)) begin
        m_owner = 1'b1;
        m_wins  = 0;
        m_beats = 0;
      end else if (bus.m0_req && bus.m1_req) m_wins++;
    end else begin
      nb = m_beats + (bus.m1_req ? 1 : 0);
      if (!bus.m1_req || (bus.m0_req && (!bus.m1_lock || nb >= MAXB))) begin
        m_owner = 1'b0;
        m_beats = 0;
      end else m_beats = nb;
    end
  endtask
  task automatic check_all(input string t);
    logic g0, g1;
    g0 = bus.m0_req & ~m_owner;
    g1 = bus.m1_req & m_owner & reset;
    chk({t, ".owner"}, 64'(bus.owner), 64'(m_owner));
    chk({t, ".m0_gnt"}, 64'(bus.m0_gnt), 64'(g0));
    chk({t, ".m1_gnt"}, 64'(bus.m1_gnt), 64'(g1));
    chk({t, ".m0_stall"}, 64'(bus.m0_stall), 64'(bus.m0_req & ~g0));
    chk({t, ".bus_we"}, 64'(bus.bus_we), 64'(reset & (m_owner ? (bus.m1_we & g1) : (bus.m0_we & g0))));
    chk({t, ".bus_addr"}, 64'(bus.bus_addr), 64'(m_owner ? bus.m1_addr : bus.m0_addr));
    chk({t, ".bus_wdata"}, 64'(bus.bus_wdata), 64'(m_owner ? bus.m1_wdata : bus.m0_wdata));
    chk({t, ".bus_mc"}, 64'(bus.bus_mem_ctrl), 64'(m_owner ? bus.m1_mem_ctrl : bus.m0_mem_ctrl));
    chk({t, ".m0_rdata"}, 64'(bus.m0_rdata), 64'(bus.bus_rdata));
    chk({t, ".m1_rdata"}, 64'(bus.m1_rdata), 64'(bus.bus_rdata));
  endtask
  task automatic cyc(input string t);
    @(negedge clk);
    check_all(t);
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic set_in(input logic m0r, input logic m0w, input logic m1r, input logic m1w, input logic lk);
    bus.m0_req  = m0r;
    bus.m0_we   = m0w;
    bus.m1_req  = m1r;
    bus.m1_we   = m1w;
    bus.m1_lock = lk;
    bus.bus_rdata = $urandom();
  endtask
  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask
  initial begin
    int nb, st;
    logic done;
    bus.m0_addr = 32'h200;
    bus.m1_addr = 32'h100;
    bus.m0_wdata = 32'hC0DE_0000;
    bus.m1_wdata = 32'hD4A0_0001;
    bus.m0_mem_ctrl = MEM_WORD;
    bus.m1_mem_ctrl = MEM_BYTE;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tv[0] = 9'b00110_0000;
    tv[1] = 9'b00110_1011;
    tv[2] = 9'b11000_1000;
    tv[3] = 9'b11000_0101;
    tv[4] = 9'b10110_0100;
    tv[5] = 9'b00100_0000;
    tv[6] = 9'b11111_1011;
    tv[7] = 9'b11100_1010;
    tv[8] = 9'b11110_0101;
    @(negedge clk);
    check_all("rst");
    chk("rst_bus_we", 64'(bus.bus_we), 64'd0);
    chk("rst_owner", 64'(bus.owner), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rel_m0_gnt", 64'(bus.m0_gnt), 64'd1);
    chk("rel_bus_we", 64'(bus.bus_we), 64'd1);
    chk("rel_addr", 64'(bus.bus_addr), 64'h200);
    cyc("rel");
    for (int i = 0; i < 10; i++) cyc("core_only");
    for (int i = 0; i < 9; i++) begin
      set_in(tv[i].m0r, tv[i].m0w, tv[i].m1r, tv[i].m1w, tv[i].lk);
      @(negedge clk);
      chk($sformatf("tv%0d.owner", i), 64'(bus.owner), 64'(tv[i].eo));
      chk($sformatf("tv%0d.m0_gnt", i), 64'(bus.m0_gnt), 64'(tv[i].eg0));
      chk($sformatf("tv%0d.m1_gnt", i), 64'(bus.m1_gnt), 64'(tv[i].eg1));
      chk($sformatf("tv%0d.bus_we", i), 64'(bus.bus_we), 64'(tv[i].ewe));
      chk($sformatf("tv%0d.addr", i), 64'(bus.bus_addr), tv[i].eo ? 64'h100 : 64'h200);
      @(posedge clk);
      model_edge();
      #1;
    end
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("acq");
    for (int k = 0; k < 3; k++) cyc("beat");
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    nb = 3;
    st = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      check_all("burst");
      if (!bus.owner) done = 1'b1;
      else begin
        nb += int'(bus.m1_gnt);
        st += int'(bus.m0_stall);
        @(posedge clk);
        model_edge();
        #1;
      end
    end
    chk("burst_done", 64'(done), 64'd1);
    chk("burst_beats", 64'(nb), 64'd16);
    chk("burst_stall", 64'(st), 64'd13);
    chk("burst_yield_gnt", 64'(bus.m0_gnt), 64'd1);
    @(posedge clk);
    model_edge();
    #1;
    do_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_all("starve");
      chk("starve_pat", 64'(bus.m1_gnt), 64'(i % 10 == 9));
      @(posedge clk);
      model_edge();
      #1;
    end
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("ar_acq");
    cyc("ar_beat");
    chk("pre_rst_we", 64'(bus.bus_we), 64'd1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_all("async");
    chk("async_we", 64'(bus.bus_we), 64'd0);
    chk("async_owner", 64'(bus.owner), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_all("post_rst");
      chk("post_rst_pat", 64'(bus.m1_gnt), 64'(i == 9));
      @(posedge clk);
      model_edge();
      #1;
    end
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      set_in(pct(60), pct(50), pct(70), pct(50), pct(80));
      bus.m0_addr = $urandom();
      bus.m1_addr = $urandom();
      bus.m0_wdata = $urandom();
      bus.m1_wdata = $urandom();
      bus.m0_mem_ctrl = 2'($urandom_range(0, 2));
      bus.m1_mem_ctrl = 2'($urandom_range(0, 2));
      cyc("rnd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
